regfile_bypass_sb: RTL
======================

REGFILE_BYPASS_SB -- requirements
Module: regfile_bypass_sb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning register width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, meaning address width; NUM_WORDS = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter NR_READ_PORTS, default 2, meaning combinational read ports.
REQ-004 SHALL have parameter NR_WRITE_PORTS, default 2, meaning writeback ports.
REQ-005 SHALL have parameter NR_ALLOC_PORTS, default 1, meaning destination-allocation ports.
REQ-006 SHALL have parameter ZERO_REG_ZERO, default 1, meaning entry 0 is hardwired zero and never pending.
REQ-007 SHALL have parameter BYPASS, default 1, meaning same-cycle write-to-read forwarding is enabled.
REQ-008 SHALL have ports: clk_i input 1 clock; rst_ni input 1 reset.
REQ-009 SHALL have port flush_i input 1, clears all pending bits.
REQ-010 SHALL have ports alloc_valid_i input NR_ALLOC_PORTS and alloc_addr_i input NR_ALLOC_PORTS x ADDR_WIDTH, marking a destination pending.
REQ-011 SHALL have ports raddr_i input NR_READ_PORTS x ADDR_WIDTH; rdata_o output NR_READ_PORTS x DATA_WIDTH; rready_o output NR_READ_PORTS, operand valid.
REQ-012 SHALL have ports we_i input NR_WRITE_PORTS; waddr_i input NR_WRITE_PORTS x ADDR_WIDTH; wdata_i input NR_WRITE_PORTS x DATA_WIDTH.
REQ-013 SHALL have port busy_o output NUM_WORDS, the current pending vector.
REQ-014 Reset rst_ni SHALL be asynchronous, active-low; clock clk_i.

Function
REQ-015 Storage: NUM_WORDS x DATA_WIDTH flip-flops mem[]; NUM_WORDS pending flops pend[].
REQ-016 Write: on a clock edge with we_i[j]=1, mem[waddr_i[j]] <= wdata_i[j]; latency 1 cycle to stored state.
REQ-017 Write collision: multiple ports writing the same address in one cycle -- the highest-index port wins, deterministically.
REQ-018 ZERO_REG_ZERO=1: writes and allocs to address 0 are ignored; reads of 0 return 0 with rready_o=1; busy_o[0]=0 always.
REQ-019 Read (combinational): BYPASS=0 -> rdata_o[i]=mem[raddr_i[i]], rready_o[i]=~pend[raddr_i[i]].
REQ-020 Read with BYPASS=1: if any we_i[j] matches raddr_i[i] (excluding address 0 when ZERO_REG_ZERO) -> rdata_o[i]=wdata_i of the highest matching port, rready_o[i]=1; otherwise as REQ-019.
REQ-021 Pending set: alloc_valid_i[k] sets pend[alloc_addr_i[k]] on the next edge.
REQ-022 Pending clear: we_i[j] clears pend[waddr_i[j]] on the next edge.
REQ-023 Same-cycle alloc and write to the same address: alloc wins; pend stays/becomes 1 (new producer), while mem still takes the write.
REQ-024 Allocating an already-pending entry: pend stays 1; no error.
REQ-025 A write to a non-pending entry updates mem; pend stays 0.
REQ-026 flush_i=1: all pend cleared on the next edge, overriding same-cycle allocs; same-cycle writes still update mem.
REQ-027 busy_o SHALL equal the registered pend vector (no combinational path from alloc/we).
REQ-028 Out-of-range conditions SHALL not exist: every ADDR_WIDTH address is a valid entry.

Reset
REQ-029 While rst_ni=0: all mem entries = 0, all pend = 0, busy_o = 0; rdata_o reads 0 with rready_o=1 for every address.
REQ-030 Reset asserted mid-operation SHALL discard in-flight writes/allocs of that cycle; first write accepted on the first edge after deassertion.

Verification
REQ-031 Reset, read all 32 addresses -> rdata_o=0, rready_o=1, busy_o=0.
REQ-032 Alloc x5; next cycle read x5 -> rready_o=0, busy_o[5]=1; write x5=0xDEAD on port 1 with BYPASS=1 -> same-cycle rdata_o=0xDEAD, rready_o=1; next cycle busy_o[5]=0.
REQ-033 Ports 0 and 1 both write x7 (0x11, 0x22) -> stored and bypassed value 0x22.
REQ-034 Alloc x9 and write x9=0x55 in the same cycle -> mem[9]=0x55, busy_o[9]=1 afterwards.
REQ-035 Pend x3,x4; flush_i with alloc x6 -> busy_o=0 next cycle; write x0=0xFF -> read x0 returns 0.
REQ-036 Assert rst_ni low for one cycle during write x8=0x1 -> mem[8]=0, busy_o=0 after release.

Source files
------------

// File: rtl/regfile_bypass_sb.sv
//============================================================================
// regfile_bypass_sb
//
// Multi-ported register file with a per-entry scoreboard ("pending") bit.
// An allocation marks a destination register as waiting for its producer,
// a writeback stores the data and retires the pending mark, and reads return
// the stored value together with an operand-ready flag. With BYPASS enabled,
// a writeback in the current cycle is forwarded straight to any matching
// read port, so a consumer does not lose a cycle waiting for the store.
//
// Parameters
//   DATA_WIDTH     register width in bits
//   ADDR_WIDTH     address width, NUM_WORDS = 2**ADDR_WIDTH entries
//   NR_READ_PORTS  combinational read ports
//   NR_WRITE_PORTS writeback ports (highest index wins on collision)
//   NR_ALLOC_PORTS destination-allocation ports
//   ZERO_REG_ZERO  entry 0 is hardwired zero and never pending
//   BYPASS         same-cycle write-to-read forwarding
//
// Ports
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   flush_i        clear every pending bit on the next edge
//   alloc_valid_i  per allocation port: mark alloc_addr_i pending
//   alloc_addr_i   per allocation port: destination address
//   raddr_i        per read port: source address
//   rdata_o        per read port: operand data
//   rready_o       per read port: operand valid (not waiting on a producer)
//   we_i           per write port: writeback enable
//   waddr_i        per write port: writeback address
//   wdata_i        per write port: writeback data
//   busy_o         registered pending vector, one bit per entry
//============================================================================
module regfile_bypass_sb #(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 5,
    parameter int NR_READ_PORTS  = 2,
    parameter int NR_WRITE_PORTS = 2,
    parameter int NR_ALLOC_PORTS = 1,
    parameter bit ZERO_REG_ZERO  = 1'b1,
    parameter bit BYPASS         = 1'b1
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      flush_i,
    input  logic [NR_ALLOC_PORTS-1:0]                 alloc_valid_i,
    input  logic [NR_ALLOC_PORTS-1:0][ADDR_WIDTH-1:0] alloc_addr_i,
    input  logic [NR_READ_PORTS-1:0][ADDR_WIDTH-1:0]  raddr_i,
    output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]  rdata_o,
    output logic [NR_READ_PORTS-1:0]                  rready_o,
    input  logic [NR_WRITE_PORTS-1:0]                 we_i,
    input  logic [NR_WRITE_PORTS-1:0][ADDR_WIDTH-1:0] waddr_i,
    input  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata_i,
    output logic [(2**ADDR_WIDTH)-1:0]                busy_o
);

    localparam int NUM_WORDS = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]     mem_q [NUM_WORDS];
    logic [DATA_WIDTH-1:0]     mem_d [NUM_WORDS];
    logic [NUM_WORDS-1:0]      pend_q;
    logic [NUM_WORDS-1:0]      pend_d;
    logic [NR_WRITE_PORTS-1:0] we_eff;
    logic [NR_ALLOC_PORTS-1:0] alloc_eff;

    // Writes and allocations aimed at the hardwired zero entry are dropped
    // here once, so neither the storage nor the forwarding path sees them.
    always_comb begin
        we_eff    = we_i;
        alloc_eff = alloc_valid_i;
        if (ZERO_REG_ZERO) begin
            for (int j = 0; j < NR_WRITE_PORTS; j++) begin
                if (waddr_i[j] == '0) begin
                    we_eff[j] = 1'b0;
                end
            end
            for (int k = 0; k < NR_ALLOC_PORTS; k++) begin
                if (alloc_addr_i[k] == '0) begin
                    alloc_eff[k] = 1'b0;
                end
            end
        end
    end

    // Next storage state. Ports are applied in ascending order so the
    // highest-index port writing an address is the one that sticks.
    always_comb begin
        mem_d = mem_q;
        for (int j = 0; j < NR_WRITE_PORTS; j++) begin
            if (we_eff[j]) begin
                mem_d[waddr_i[j]] = wdata_i[j];
            end
        end
    end

    // Next pending state. Writebacks retire first and allocations are applied
    // afterwards, so a same-cycle alloc to a written entry leaves it pending
    // for the new producer. A flush overrides everything.
    always_comb begin
        pend_d = pend_q;
        for (int j = 0; j < NR_WRITE_PORTS; j++) begin
            if (we_eff[j]) begin
                pend_d[waddr_i[j]] = 1'b0;
            end
        end
        for (int k = 0; k < NR_ALLOC_PORTS; k++) begin
            if (alloc_eff[k]) begin
                pend_d[alloc_addr_i[k]] = 1'b1;
            end
        end
        if (flush_i) begin
            pend_d = '0;
        end
        if (ZERO_REG_ZERO) begin
            pend_d[0] = 1'b0;
        end
    end

    // Storage and scoreboard registers; reset clears both, which also
    // discards whatever write or allocation was presented during reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                mem_q[w] <= '0;
            end
            pend_q <= '0;
        end else begin
            mem_q  <= mem_d;
            pend_q <= pend_d;
        end
    end

    // Read ports. The forwarding loop runs in ascending port order so the
    // highest matching writeback provides the data. While reset is held the
    // outputs are forced to zero/ready so a writeback presented during reset
    // cannot leak through the bypass path.
    always_comb begin
        rdata_o  = '0;
        rready_o = '1;
        for (int i = 0; i < NR_READ_PORTS; i++) begin
            rdata_o[i]  = mem_q[raddr_i[i]];
            rready_o[i] = ~pend_q[raddr_i[i]];
            if (BYPASS) begin
                for (int j = 0; j < NR_WRITE_PORTS; j++) begin
                    if (we_eff[j] && (waddr_i[j] == raddr_i[i])) begin
                        rdata_o[i]  = wdata_i[j];
                        rready_o[i] = 1'b1;
                    end
                end
            end
            if (ZERO_REG_ZERO && (raddr_i[i] == '0)) begin
                rdata_o[i]  = '0;
                rready_o[i] = 1'b1;
            end
            if (!rst_ni) begin
                rdata_o[i]  = '0;
                rready_o[i] = 1'b1;
            end
        end
    end

    assign busy_o = pend_q;

endmodule
